alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_arbiter_if.sv | 40 ++++
 rtl/rr_arbiter2.sv | 16 +
 rtl/alu_arbiter.sv | 78 +++++++
 tb/tb_alu_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: FSM state type, ALU opcode constants and opcode helpers
package alu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  localparam logic [3:0] OP_DIV = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_SLT = 4'd10;
  localparam logic [3:0] OP_NOT = 4'd11;
  localparam logic [3:0] OP_LAST_LEGAL = OP_NOT;
  function automatic logic is_muldiv(logic [3:0] op);
    return op <= OP_MUL;
  endfunction
  function automatic logic is_legal(logic [3:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and ALU-side signals of the arbiter
interface alu_arbiter_if;
  logic req0_valid;
  logic req0_ready;
  logic [3:0] req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic req1_valid;
  logic req1_ready;
  logic [3:0] req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic rsp_valid;
  logic rsp_ready;
  logic rsp_id;
  logic [31:0] rsp_lo;
  logic [31:0] rsp_hi;
  logic rsp_err;
  logic [31:0] alu_reg1;
  logic [31:0] alu_reg2;
  logic [3:0] alu_control;
  logic alu_inc_pc;
  logic [31:0] alu_z1;
  logic [31:0] alu_z2;
  logic busy;
  modport slave (
    input req0_valid, req0_op, req0_a, req0_b,
    input req1_valid, req1_op, req1_a, req1_b,
    input rsp_ready, alu_z1, alu_z2,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_err,
    output alu_reg1, alu_reg2, alu_control, alu_inc_pc, busy
  );
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready, alu_z1, alu_z2,
    input req0_ready, req1_ready, rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_err,
    input alu_reg1, alu_reg2, alu_control, alu_inc_pc, busy
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with a last-grant pointer
module rr_arbiter2 (
  input logic clk,
  input logic rst_n,
  input logic en,
  input logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;
  // on a tie favour the requester not served last, otherwise whoever asks
  always_comb gnt = !en ? 2'b00 : &req ? (last ? 2'b01 : 2'b10) : req;
  // a grant is always taken (valid is part of it), so the pointer follows it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (|gnt) last <= gnt[1];
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end sharing one multi-cycle ALU between two requesters
module alu_arbiter import alu_pkg::*; #(
  parameter int MULDIV_LAT = 4,
  parameter int SIMPLE_LAT = 1
) (
  input logic Clk,
  input logic Clear_n,
  alu_arbiter_if.slave bus
);
  localparam logic [3:0] MD_LAT = 4'(MULDIV_LAT);
  localparam logic [3:0] SP_LAT = 4'(SIMPLE_LAT);
  state_t state, state_nxt;
  logic [1:0] gnt;
  logic accept;
  logic legal;
  logic [3:0] op_in;
  logic [3:0] cnt;
  logic [31:0] a_in;
  logic [31:0] b_in;
  rr_arbiter2 u_rr (
    .clk(Clk),
    .rst_n(Clear_n),
    .en(state == IDLE),
    .req({bus.req1_valid, bus.req0_valid}),
    .gnt(gnt)
  );
  assign accept = |gnt;
  assign op_in = gnt[1] ? bus.req1_op : bus.req0_op;
  assign a_in = gnt[1] ? bus.req1_a : bus.req0_a;
  assign b_in = gnt[1] ? bus.req1_b : bus.req0_b;
  assign legal = is_legal(op_in);
  // state register
  always_ff @(posedge Clk or negedge Clear_n)
    if (!Clear_n) state <= IDLE;
    else state <= state_nxt;
  // illegal ops skip the ALU and answer straight away
  always_comb
    state_nxt = state == IDLE ? (accept ? (legal ? EXEC : RESP) : IDLE)
              : state == EXEC ? (cnt == 4'd1 ? RESP : EXEC)
              : (bus.rsp_ready ? IDLE : RESP);
  // handshake and status outputs
  always_comb begin
    bus.req0_ready = gnt[0];
    bus.req1_ready = gnt[1];
    bus.rsp_valid = state == RESP;
    bus.busy = state != IDLE;
    bus.alu_inc_pc = 1'b0;
  end
  // operand latch, latency counter and result capture; ALU inputs only move on legal ops
  always_ff @(posedge Clk or negedge Clear_n)
    if (!Clear_n) begin
      cnt <= '0;
      bus.rsp_id <= 1'b0;
      bus.rsp_err <= 1'b0;
      bus.rsp_lo <= '0;
      bus.rsp_hi <= '0;
      bus.alu_reg1 <= '0;
      bus.alu_reg2 <= '0;
      bus.alu_control <= '0;
    end else if (accept) begin
      cnt <= !legal ? 4'd0 : is_muldiv(op_in) ? MD_LAT : SP_LAT;
      bus.rsp_id <= gnt[1];
      bus.rsp_err <= !legal;
      bus.rsp_lo <= '0;
      bus.rsp_hi <= '0;
      if (legal) begin
        bus.alu_reg1 <= a_in;
        bus.alu_reg2 <= b_in;
        bus.alu_control <= op_in;
      end
    end else if (state == EXEC) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        bus.rsp_lo <= bus.alu_z1;
        bus.rsp_hi <= is_muldiv(bus.alu_control) ? bus.alu_z2 : '0;
      end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  import alu_pkg::*;
  logic Clk = 1'b0;
  logic Clear_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [63:0] prod;
  alu_arbiter_if bus();
  alu_arbiter #(.MULDIV_LAT(4), .SIMPLE_LAT(1)) dut (
    .Clk(Clk),
    .Clear_n(Clear_n),
    .bus(bus.slave)
  );
  always #5 Clk = ~Clk;
  assign prod = {32'b0, bus.alu_reg1} * {32'b0, bus.alu_reg2};
  // behavioural ALU; z2 carries junk for simple ops so the arbiter must zero rsp_hi
  always_comb begin
    bus.alu_z1 = bus.alu_reg1 ^ bus.alu_reg2;
    bus.alu_z2 = 32'hDEAD_BEEF;
    case (bus.alu_control)
      OP_DIV: begin
        bus.alu_z1 = bus.alu_reg2 == 0 ? '1 : bus.alu_reg1 / bus.alu_reg2;
        bus.alu_z2 = bus.alu_reg2 == 0 ? bus.alu_reg1 : bus.alu_reg1 % bus.alu_reg2;
      end
      OP_MUL: {bus.alu_z2, bus.alu_z1} = prod;
      OP_ADD: bus.alu_z1 = bus.alu_reg1 + bus.alu_reg2;
      OP_SUB: bus.alu_z1 = bus.alu_reg1 - bus.alu_reg2;
      OP_AND: bus.alu_z1 = bus.alu_reg1 & bus.alu_reg2;
      OP_OR: bus.alu_z1 = bus.alu_reg1 | bus.alu_reg2;
      default: ;
    endcase
  end
  task automatic do_reset;
    Clear_n = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Clear_n = 1'b1;
  endtask
  task automatic send(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output bit ok);
    ok = 1'b0;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
    for (int i = 0; i < 20 && !ok; i++) begin
      #1 ok = id ? bus.req1_ready : bus.req0_ready;
      @(negedge Clk);
    end
    if (id) bus.req1_valid = 1'b0;
    else bus.req0_valid = 1'b0;
  endtask
  task automatic wait_rsp(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      if (bus.rsp_valid) begin
        n = i;
        break;
      end
      @(negedge Clk);
    end
  endtask
  task automatic take;
    bus.rsp_ready = 1'b1;
    @(negedge Clk);
    bus.rsp_ready = 1'b0;
  endtask
  task automatic test_reset;
    @(negedge Clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.rsp_lo !== 32'd0 || bus.rsp_hi !== 32'd0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp got lo=%h hi=%h err=%b want 0", bus.rsp_lo, bus.rsp_hi, bus.rsp_err); end
    checks++; if (bus.alu_control !== 4'd0 || bus.alu_reg1 !== 32'd0 || bus.alu_inc_pc !== 1'b0) begin errors++; $display("FAIL reset_alu got ctl=%h r1=%h inc=%b want 0", bus.alu_control, bus.alu_reg1, bus.alu_inc_pc); end
    @(negedge Clk);
    Clear_n = 1'b1;
    @(negedge Clk);
  endtask
  task automatic test_simple;
    bit ok;
    int n;
    send(1'b0, OP_ADD, 32'd5, 32'd7, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL simple_accept got %b want 1", ok); end
    checks++; if (bus.alu_reg1 !== 32'd5 || bus.alu_reg2 !== 32'd7 || bus.alu_control !== OP_ADD) begin errors++; $display("FAIL simple_alu_in got %h %h %h want 5 7 2", bus.alu_reg1, bus.alu_reg2, bus.alu_control); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL simple_busy got %b want 1", bus.busy); end
    wait_rsp(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL simple_latency got %0d want 2", n); end
    checks++; if (bus.rsp_lo !== 32'd12 || bus.rsp_hi !== 32'd0 || bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL simple_rsp got lo=%0d hi=%h id=%b err=%b want 12 0 0 0", bus.rsp_lo, bus.rsp_hi, bus.rsp_id, bus.rsp_err); end
    take();
    checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL simple_idle got busy=%b valid=%b want 0 0", bus.busy, bus.rsp_valid); end
  endtask
  task automatic test_tie;
    int n;
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'd10; bus.req0_b = 32'd3;
    bus.req1_valid = 1'b1; bus.req1_op = OP_SUB; bus.req1_a = 32'd10; bus.req1_b = 32'd3;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if ({bus.req1_ready, bus.req0_ready} !== (k % 2 == 0 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL tie_grant%0d got %b want %b", k, {bus.req1_ready, bus.req0_ready}, (k % 2 == 0 ? 2'b01 : 2'b10)); end
      @(negedge Clk);
      checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin errors++; $display("FAIL tie_ready_exec%0d got %b want 00", k, {bus.req1_ready, bus.req0_ready}); end
      wait_rsp(n);
      checks++; if (n !== 2 || bus.rsp_id !== k[0] || bus.rsp_lo !== (k[0] ? 32'd7 : 32'd13)) begin errors++; $display("FAIL tie_rsp%0d got n=%0d id=%b lo=%0d want 2 %b %0d", k, n, bus.rsp_id, bus.rsp_lo, k[0], (k[0] ? 7 : 13)); end
      bus.rsp_ready = 1'b1;
      #1;
      checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin errors++; $display("FAIL tie_ready_hs%0d got %b want 00", k, {bus.req1_ready, bus.req0_ready}); end
      @(negedge Clk);
      bus.rsp_ready = 1'b0;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge Clk);
  endtask
  task automatic test_illegal;
    bit ok;
    int n;
    send(1'b1, 4'd13, 32'd1, 32'd2, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL illegal_accept got %b want 1", ok); end
    wait_rsp(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL illegal_latency got %0d want 1", n); end
    checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_lo !== 32'd0 || bus.rsp_hi !== 32'd0) begin errors++; $display("FAIL illegal_rsp got err=%b id=%b lo=%h hi=%h want 1 1 0 0", bus.rsp_err, bus.rsp_id, bus.rsp_lo, bus.rsp_hi); end
    checks++; if (bus.alu_control !== OP_SUB || bus.alu_reg1 !== 32'd10) begin errors++; $display("FAIL illegal_alu got ctl=%h r1=%0d want 3 10", bus.alu_control, bus.alu_reg1); end
    take();
  endtask
  task automatic test_muldiv;
    bit ok;
    int n;
    send(1'b0, OP_MUL, 32'h0001_0000, 32'h0001_0000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mul_accept got %b want 1", ok); end
    wait_rsp(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL mul_latency got %0d want 5", n); end
    checks++; if (bus.rsp_lo !== 32'd0 || bus.rsp_hi !== 32'd1 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL mul_rsp got lo=%h hi=%h err=%b want 0 1 0", bus.rsp_lo, bus.rsp_hi, bus.rsp_err); end
    take();
    send(1'b1, OP_DIV, 32'd100, 32'd7, ok);
    wait_rsp(n);
    checks++; if (n !== 5 || bus.rsp_lo !== 32'd14 || bus.rsp_hi !== 32'd2 || bus.rsp_id !== 1'b1) begin errors++; $display("FAIL div_rsp got n=%0d lo=%0d hi=%0d id=%b want 5 14 2 1", n, bus.rsp_lo, bus.rsp_hi, bus.rsp_id); end
    take();
  endtask
  task automatic test_stall;
    bit ok;
    int n;
    send(1'b0, OP_ADD, 32'd1, 32'd2, ok);
    wait_rsp(n);
    bus.req1_valid = 1'b1; bus.req1_op = OP_AND; bus.req1_a = 32'hF0; bus.req1_b = 32'h3C;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_lo !== 32'd3 || bus.rsp_id !== 1'b0 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL stall%0d got valid=%b lo=%0d id=%b rdy=%b want 1 3 0 0", i, bus.rsp_valid, bus.rsp_lo, bus.rsp_id, bus.req1_ready); end
      @(negedge Clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL stall_hs_ready got %b want 0", bus.req1_ready); end
    @(negedge Clk);
    bus.rsp_ready = 1'b0;
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL stall_after_ready got %b want 1", bus.req1_ready); end
    @(negedge Clk);
    bus.req1_valid = 1'b0;
    wait_rsp(n);
    checks++; if (n !== 2 || bus.rsp_lo !== 32'h30 || bus.rsp_id !== 1'b1) begin errors++; $display("FAIL stall_held_rsp got n=%0d lo=%h id=%b want 2 30 1", n, bus.rsp_lo, bus.rsp_id); end
    take();
  endtask
  task automatic test_reset_mid;
    bit ok;
    int seen;
    send(1'b0, OP_DIV, 32'd100, 32'd7, ok);
    @(negedge Clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", bus.busy); end
    #2 Clear_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.alu_control !== 4'd0 || bus.alu_reg1 !== 32'd0 || bus.alu_reg2 !== 32'd0) begin errors++; $display("FAIL mid_reset got busy=%b valid=%b ctl=%h r1=%h r2=%h want all 0", bus.busy, bus.rsp_valid, bus.alu_control, bus.alu_reg1, bus.alu_reg2); end
    checks++; if (bus.rsp_id !== 1'b0 || bus.rsp_lo !== 32'd0 || bus.rsp_hi !== 32'd0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL mid_reset_rsp got id=%b lo=%h hi=%h err=%b want 0", bus.rsp_id, bus.rsp_lo, bus.rsp_hi, bus.rsp_err); end
    @(negedge Clk);
    Clear_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (bus.rsp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_rsp got %0d valid cycles want 0", seen); end
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin errors++; $display("FAIL mid_ptr got %b want 01", {bus.req1_ready, bus.req0_ready}); end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge Clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b want 0", bus.busy); end
  endtask
  initial begin
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_simple();
    test_tie();
    test_illegal();
    test_muldiv();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
